// File: rtl/cdr_loop_dco_if.sv
// Loop-side signal bundle for the CDR loop filter / DCO.
// The phase detector side (master) drives up/down/enable; the loop (slave)
// returns the recovered clock, frequency word, integrator and lock flag.
interface cdr_loop_dco_if #(
   parameter int ACC_W = 16,
   parameter int INT_W = 10
);
   logic                    up;
   logic                    down;
   logic                    enable;
   logic                    crc_clk;
   logic [ACC_W-1:0]        freq_word;
   logic signed [INT_W-1:0] integ;
   logic                    locked;

   modport master (
      output up, down, enable,
      input  crc_clk, freq_word, integ, locked
   );

   modport slave (
      input  up, down, enable,
      output crc_clk, freq_word, integ, locked
   );
endinterface

// File: rtl/cdr_loop_dco.sv
// Proportional-integral loop filter plus phase-accumulator DCO for clock
// recovery. Phase-detector up/down pulses are synchronized, edge-detected,
// decoded to a direction, and turned into a clamped frequency word that
// steps a phase accumulator whose MSB is the recovered clock.
module cdr_loop_dco #(
   parameter int               ACC_W    = 16,
   parameter int               INT_W    = 10,
   parameter logic [ACC_W-1:0] NOM_INC  = 16'h1000,
   parameter int               KP       = 4,
   parameter int               KI       = 1,
   parameter int               INT_LIM  = 255,
   parameter int               LOCK_WIN = 64
) (
   input logic           clk,
   input logic           rst_n,
   cdr_loop_dco_if.slave bus
);

   localparam int QW = $clog2(LOCK_WIN + 1);
   localparam logic [QW-1:0] LOCK_X = QW'(LOCK_WIN);

   localparam logic signed [INT_W:0] LIM_P = (INT_W+1)'(INT_LIM);
   localparam logic signed [INT_W:0] LIM_N = -LIM_P;
   localparam logic signed [INT_W:0] KI_X  = (INT_W+1)'(KI);

   localparam logic signed [ACC_W+1:0] KP_X  = (ACC_W+2)'(KP);
   localparam logic signed [ACC_W+1:0] NOM_X = {2'b00, NOM_INC};
   localparam logic signed [ACC_W+1:0] F_MIN = {{(ACC_W+1){1'b0}}, 1'b1};
   localparam logic signed [ACC_W+1:0] F_MAX = {3'b001, {(ACC_W-1){1'b0}}};

   // synchronizer and edge-detect registers
   logic up_meta_q, up_sync_q, up_last_q;
   logic dn_meta_q, dn_sync_q, dn_last_q;

   // loop state
   logic signed [INT_W-1:0] integ_q, integ_d;
   logic [ACC_W-1:0]        freq_q, freq_d;
   logic [ACC_W-1:0]        phase_q, phase_d;
   logic                    crc_q, crc_d;
   logic [QW-1:0]           quiet_q, quiet_d;

   logic up_evt, dn_evt;
   logic dir_up, dir_dn;

   logic signed [INT_W:0]   integ_ext;
   logic signed [INT_W:0]   integ_sum;
   logic signed [ACC_W+1:0] kp_term;
   logic signed [ACC_W+1:0] fsum;

   // Synchronizers run regardless of enable so re-enabling never sees a stale edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         up_meta_q <= 1'b0;
         up_sync_q <= 1'b0;
         up_last_q <= 1'b0;
         dn_meta_q <= 1'b0;
         dn_sync_q <= 1'b0;
         dn_last_q <= 1'b0;
      end else begin
         up_meta_q <= bus.up;
         up_sync_q <= up_meta_q;
         up_last_q <= up_sync_q;
         dn_meta_q <= bus.down;
         dn_sync_q <= dn_meta_q;
         dn_last_q <= dn_sync_q;
      end
   end

   // Events are dropped while disabled; simultaneous up/down cancel out.
   assign up_evt = up_sync_q & ~up_last_q & bus.enable;
   assign dn_evt = dn_sync_q & ~dn_last_q & bus.enable;
   assign dir_up = up_evt & ~dn_evt;
   assign dir_dn = dn_evt & ~up_evt;

   // Saturating integrator: computed one bit wider so the limit test cannot wrap.
   always_comb begin
      integ_ext = {integ_q[INT_W-1], integ_q};
      integ_sum = integ_ext;
      if (dir_up) begin
         integ_sum = integ_ext + KI_X;
         if (integ_sum > LIM_P) integ_sum = LIM_P;
      end else if (dir_dn) begin
         integ_sum = integ_ext - KI_X;
         if (integ_sum < LIM_N) integ_sum = LIM_N;
      end
      integ_d = integ_sum[INT_W-1:0];
   end

   // Frequency word: nominal + integrator + one-cycle proportional kick, clamped.
   always_comb begin
      kp_term = '0;
      if (dir_up)      kp_term = KP_X;
      else if (dir_dn) kp_term = -KP_X;
      fsum = NOM_X + {{(ACC_W+2-INT_W){integ_d[INT_W-1]}}, integ_d} + kp_term;
      freq_d = fsum[ACC_W-1:0];
      if (fsum < F_MIN)      freq_d = ACC_W'(1);
      else if (fsum > F_MAX) freq_d = {1'b1, {(ACC_W-1){1'b0}}};
   end

   // Phase accumulator wraps naturally; recovered clock is its MSB, one clk late.
   always_comb begin
      phase_d = phase_q + freq_q;
      crc_d   = phase_q[ACC_W-1];
   end

   // Quiet counter saturates at the lock window; any correction or disable clears it.
   always_comb begin
      quiet_d = quiet_q;
      if (!bus.enable || dir_up || dir_dn) quiet_d = '0;
      else if (quiet_q < LOCK_X)           quiet_d = quiet_q + QW'(1);
   end

   // Loop state registers; everything except the quiet counter holds while disabled.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         integ_q <= '0;
         freq_q  <= NOM_INC;
         phase_q <= '0;
         crc_q   <= 1'b0;
         quiet_q <= '0;
      end else begin
         quiet_q <= quiet_d;
         if (bus.enable) begin
            integ_q <= integ_d;
            freq_q  <= freq_d;
            phase_q <= phase_d;
            crc_q   <= crc_d;
         end
      end
   end

   assign bus.crc_clk   = crc_q;
   assign bus.freq_word = freq_q;
   assign bus.integ     = integ_q;
   assign bus.locked    = (quiet_q >= LOCK_X);

endmodule

// File: tb/tb_cdr_loop_dco.sv
// Directed bench for cdr_loop_dco: free run, table of single pulses,
// saturation, enable freeze and asynchronous mid-operation reset.
module tb_cdr_loop_dco;

   logic clk = 1'b0;
   logic rst_n;

   always #5 clk = ~clk;

   cdr_loop_dco_if #(.ACC_W(16), .INT_W(10)) bus_if ();

   cdr_loop_dco dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus_if)
   );

   int n_checks = 0;
   int n_fail   = 0;

   typedef struct {
      logic up;
      logic dn;
      int   width;
      int   exp_integ;
      int   exp_fw_pulse;
      int   exp_fw_after;
      logic exp_lock;
   } vec_t;

   vec_t vecs [6];

   task automatic chk(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      bus_if.up     = 1'b0;
      bus_if.down   = 1'b0;
      bus_if.enable = 1'b1;
      rst_n         = 1'b0;
      repeat (3) tick();
      chk("rst freq_word", int'(bus_if.freq_word), 'h1000);
      chk("rst integ",     int'(bus_if.integ),     0);
      chk("rst crc_clk",   int'(bus_if.crc_clk),   0);
      chk("rst locked",    int'(bus_if.locked),    0);
      rst_n = 1'b1;
   endtask

   // Drive up/down for w cycles; the event lands 3 edges after the drive starts.
   task automatic pulse_check(input int idx, input logic u, input logic d, input int w,
                              input int ei, input int efp, input int efa, input logic el);
      bus_if.up   = u;
      bus_if.down = d;
      for (int c = 1; c <= 8; c++) begin
         tick();
         if (c == w) begin
            bus_if.up   = 1'b0;
            bus_if.down = 1'b0;
         end
         if (c == 3) begin
            chk($sformatf("v%0d integ", idx),         int'(bus_if.integ),     ei);
            chk($sformatf("v%0d fw_pulse", idx),      int'(bus_if.freq_word), efp);
            chk($sformatf("v%0d locked_evt", idx),    int'(bus_if.locked),    int'(el));
         end
         if (c == 4)
            chk($sformatf("v%0d fw_after", idx),      int'(bus_if.freq_word), efa);
      end
   endtask

   initial begin
      bit found;

      vecs[0] = '{1'b1, 1'b0, 3,  1, 'h1005, 'h1001, 1'b0};
      vecs[1] = '{1'b0, 1'b1, 3,  0, 'h0FFC, 'h1000, 1'b0};
      vecs[2] = '{1'b0, 1'b1, 2, -1, 'h0FFB, 'h0FFF, 1'b0};
      vecs[3] = '{1'b1, 1'b1, 3, -1, 'h0FFF, 'h0FFF, 1'b1};
      vecs[4] = '{1'b0, 1'b1, 1, -2, 'h0FFA, 'h0FFE, 1'b0};
      vecs[5] = '{1'b1, 1'b0, 5, -1, 'h1003, 'h0FFF, 1'b0};

      rst_n         = 1'b1;
      bus_if.up     = 1'b0;
      bus_if.down   = 1'b0;
      bus_if.enable = 1'b1;
      #2;

      // free run: 16-clk period, first rise on edge 9, lock on edge 64
      do_reset();
      for (int n = 1; n <= 70; n++) begin
         tick();
         chk($sformatf("free crc_clk n=%0d", n), int'(bus_if.crc_clk), (((n - 1) % 16) >= 8) ? 1 : 0);
         if (n == 63) chk("free locked n=63", int'(bus_if.locked), 0);
         if (n == 64) chk("free locked n=64", int'(bus_if.locked), 1);
      end
      chk("free freq_word", int'(bus_if.freq_word), 'h1000);

      // table of single pulses, each preceded by a locked quiet stretch
      for (int i = 0; i < 6; i++) begin
         repeat (70) tick();
         chk($sformatf("v%0d pre_lock", i), int'(bus_if.locked), 1);
         pulse_check(i, vecs[i].up, vecs[i].dn, vecs[i].width, vecs[i].exp_integ,
                     vecs[i].exp_fw_pulse, vecs[i].exp_fw_after, vecs[i].exp_lock);
      end

      // single down pulse from reset
      do_reset();
      pulse_check(10, 1'b0, 1'b1, 3, -1, 'h0FFB, 'h0FFF, 1'b0);

      // saturation at +255
      do_reset();
      for (int i = 0; i < 300; i++) begin
         bus_if.up = 1'b1;
         tick();
         bus_if.up = 1'b0;
         repeat (3) tick();
      end
      repeat (4) tick();
      chk("sat integ",     int'(bus_if.integ),     255);
      chk("sat freq_word", int'(bus_if.freq_word), 'h10FF);
      pulse_check(20, 1'b1, 1'b0, 1, 255, 'h1103, 'h10FF, 1'b0);

      // enable freeze with up held across re-enable
      do_reset();
      repeat (76) tick();
      chk("en pre crc_clk", int'(bus_if.crc_clk), 1);
      chk("en pre locked",  int'(bus_if.locked),  1);
      bus_if.enable = 1'b0;
      tick();
      chk("en off locked", int'(bus_if.locked), 0);
      bus_if.up = 1'b1;
      for (int k = 1; k <= 10; k++) begin
         tick();
         chk($sformatf("en off crc_clk k=%0d", k), int'(bus_if.crc_clk), 1);
      end
      chk("en off integ",     int'(bus_if.integ),     0);
      chk("en off freq_word", int'(bus_if.freq_word), 'h1000);
      bus_if.enable = 1'b1;
      for (int k = 1; k <= 6; k++) begin
         tick();
         chk($sformatf("en on crc_clk k=%0d", k), int'(bus_if.crc_clk), (k <= 4) ? 1 : 0);
         chk($sformatf("en on integ k=%0d", k),   int'(bus_if.integ),   0);
      end
      chk("en on freq_word", int'(bus_if.freq_word), 'h1000);
      bus_if.up = 1'b0;
      repeat (4) tick();

      // asynchronous reset during a high phase
      pulse_check(30, 1'b1, 1'b0, 3, 1, 'h1005, 'h1001, 1'b0);
      found = 1'b0;
      for (int k = 0; k < 40 && !found; k++) begin
         tick();
         if (bus_if.crc_clk == 1'b1) found = 1'b1;
      end
      chk("mid crc_high_found", int'(found), 1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("mid crc_clk",   int'(bus_if.crc_clk),   0);
      chk("mid freq_word", int'(bus_if.freq_word), 'h1000);
      chk("mid integ",     int'(bus_if.integ),     0);
      chk("mid locked",    int'(bus_if.locked),    0);
      tick();
      rst_n = 1'b1;
      repeat (2) tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/cdr_loop_dco.md
# cdr_loop_dco

Digital loop filter and numerically controlled oscillator for the clock-recovery path. It consumes the `up`/`down` pulses from the phase detector and turns them into a proportional-integral frequency correction. It runs a phase accumulator whose MSB is the recovered clock `crc_clk`, which feeds back to the phase detector's internal-clock input and drives the downstream data sampler.

## Interface

Parameters:
- `ACC_W`, 16: phase accumulator and frequency word width.
- `INT_W`, 10: signed integrator width.
- `NOM_INC`, 16'h1000: nominal frequency word (crc_clk = clk·NOM_INC/2^ACC_W).
- `KP`, 4: proportional step applied in the event cycle only.
- `KI`, 1: integrator step per event.
- `INT_LIM`, 255: integrator saturation magnitude (symmetric).
- `LOCK_WIN`, 64: quiet cycles required for lock.

Ports:
- `clk` in 1: single system clock; all state on rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `up` in 1: phase-detector output, asynchronous to `clk`.
- `down` in 1: phase-detector output, asynchronous to `clk`.
- `enable` in 1: loop run enable, synchronous.
- `crc_clk` out 1: recovered clock, registered.
- `freq_word` out ACC_W: current registered increment.
- `integ` out INT_W: signed integrator value.
- `locked` out 1: lock indicator.

## Operation

- **Input capture.** `up` and `down` each pass through a 2-FF synchronizer followed by a rising-edge detector.
  - This produces one-cycle `up_evt`/`dn_evt` pulses.
  - A level held high counts as one event.
- **Direction decode.**
  - `up_evt` & !`dn_evt` gives dir = +1.
  - `dn_evt` & !`up_evt` gives dir = −1.
  - Both or neither gives dir = 0, with no correction and no lock disturbance.
- **Integrator.** On dir = ±1, `integ` moves by ±KI.
  - It saturates at +INT_LIM and −INT_LIM and never wraps.
  - An event at the limit holds the value.
- **Frequency word.** The next value is NOM_INC + sext(`integ`_next) + dir·KP.
  - The sum is computed at ACC_W+2 bits signed.
  - It is clamped to the range 1 … 2^(ACC_W−1).
  - The result is registered into `freq_word`.
  - The KP term is present for exactly one cycle per event.
- **Phase accumulator.** `phase` ← `phase` + `freq_word`, modulo 2^ACC_W, with natural wrap. `crc_clk` ← `phase`[ACC_W−1].
- **Lock detector.**
  - A saturating quiet counter increments each cycle with dir = 0.
  - Any dir ≠ 0 clears the counter to 0.
  - `locked` = 1 while the counter ≥ LOCK_WIN.
- **`enable` = 0.**
  - `phase`, `crc_clk`, `integ` and `freq_word` hold.
  - Events are discarded, but the synchronizers keep running so no stale edge is produced when re-enabled.
  - The quiet counter clears and `locked` goes to 0.
- **Reset values (async on `rst_n` = 0).**
  - `phase` = 0, `crc_clk` = 0, `integ` = 0.
  - `freq_word` = NOM_INC.
  - Quiet counter = 0, `locked` = 0.
  - Synchronizer and edge registers = 0.

## Timing

- Async rise of `up`/`down` to event pulse: 2–3 clk, due to synchronizer uncertainty.
- Event pulse to `integ` and `freq_word` updated: 1 clk, registered.
- `freq_word` change to phase step: the next clk.
- `crc_clk` trails the phase MSB by 1 clk.
- Event to `locked` deassert: 1 clk after the event pulse.
- Lock assert: first cycle after LOCK_WIN consecutive quiet cycles.
- Mid-operation reset: all state returns to reset values immediately. After release, the first event is honoured only after the synchronizer refills (≥2 clk).
- Rising `up` edges spaced closer than 2 clk may merge into one event; this is acceptable.

## Test plan

- **Reset and free run.** Release reset with `enable` = 1 and no pulses.
  - `freq_word` = 0x1000.
  - `crc_clk` has a 16-clk period: 8 high, 8 low, first rise 9 clk after release.
  - `locked` rises after 64 clk.
- **Single up pulse** (3 clk wide).
  - `integ` = 1.
  - `freq_word` = 0x1005 for one cycle, then 0x1001.
  - `locked` drops, then re-asserts 64 quiet cycles later.
- **Single down pulse from reset.**
  - `integ` = −1.
  - `freq_word` = 0x0FFB for one cycle, then 0x0FFF.
- **Saturation.** Apply 300 separated up pulses.
  - `integ` stops at 255 and `freq_word` settles at 0x10FF.
  - A further up pulse leaves `integ` at 255.
- **Simultaneous events.** Drive `up` and `down` rising on the same clk.
  - `integ` and `freq_word` are unchanged.
  - The quiet counter is not cleared.
- **Enable and mid-operation reset.**
  - Drop `enable` mid-period: `crc_clk`/`phase` freeze, `locked` = 0, and pulses have no effect.
  - Assert `rst_n` = 0 during a high phase: `crc_clk` goes low asynchronously and all outputs return to reset values.
